data_table_insert: RTL and testbench
====================================

Name: data_table_insert

Overview:
Write-side companion of the chain search engine in the hash table data path. Accepts one insert task (key, value, bucket, head pointer) at a time and walks the bucket's chain in data table RAM. It then does one of three things: overwrites a matching entry, appends a freshly allocated entry at the tail, or creates the chain and updates the head table. Emits one ht_result_t per task.

Parameters:
A_WIDTH, TABLE_ADDR_WIDTH, data table RAM address width (also the empty-pointer and head-pointer width).

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; synchronous, active-high, sampled on rising edge of clk_i
task_i  in  ht_pdata_t  cmd.key, cmd.value, bucket, head_ptr, head_ptr_val
task_valid_i  in  1  task valid
task_ready_o  out  1  high only in IDLE_S
rd_avail_i  in  1  RAM read port grant
rd_addr_o  out  A_WIDTH  read address
rd_en_o  out  1  read strobe = rd_avail_i && state in {READ_HEAD_S, GO_ON_CHAIN_S} && !rd_pending
rd_data_i  in  ram_data_t  key, value, next_ptr, next_ptr_val
rd_data_val_i  in  1  read data valid (any latency >= 1)
wr_avail_i  in  1  RAM write port grant
wr_addr_o  out  A_WIDTH  write address
wr_data_o  out  ram_data_t  write data
wr_en_o  out  1  write strobe; write happens in the cycle wr_en_o is high
empty_addr_i  in  A_WIDTH  next free RAM address
empty_addr_val_i  in  1  free address available (low = table full)
empty_addr_rd_ack_o  out  1  one-cycle pop of empty_addr_i
head_table_wr_addr_o  out  BUCKET_WIDTH  bucket to update
head_table_wr_data_ptr_o  out  A_WIDTH  new head pointer
head_table_wr_data_ptr_val_o  out  1  new head valid (always 1 when written)
head_table_wr_en_o  out  1  one-cycle head table write, no backpressure
result_o  out  ht_result_t  cmd, bucket, rescode, chain_state; found_value = '0
result_valid_o  out  1  result valid
result_ready_i  in  1  result accepted

Behaviour:
- Reset: state IDLE_S. Locked task, rd_addr, tail copy and chain_state clear to 0. All strobes and result_valid_o are low. Reset mid-task abandons the task: no further writes and no ack.
- Task accepted on task_valid_i && task_ready_o and locked for the whole operation.
- IDLE_S: head_ptr_val=0 goes to ALLOC_S with mode NEW_HEAD. Otherwise go to READ_HEAD_S with rd_addr <= head_ptr.
- READ_HEAD_S / GO_ON_CHAIN_S:
  - Issue exactly one read per visit; rd_pending is set on rd_en_o and cleared on rd_data_val_i.
  - On rd_data_val_i with key match: record match address = rd_addr and go to KEY_MATCH_S.
  - Else, with next_ptr_val=0: record tail address and tail data, set mode APPEND, go to ALLOC_S.
  - Else: rd_addr <= next_ptr and go to GO_ON_CHAIN_S.
- ALLOC_S: empty_addr_val_i=1 → pulse empty_addr_rd_ack_o for one cycle, latch new address, go to WRITE_NEW_S. empty_addr_val_i=0 → rescode INSERT_NOT_SUCCESS_TABLE_IS_FULL, go to RESULT_S, no ack, no writes.
- WRITE_NEW_S: wr_en_o = wr_avail_i, writing {key, value, next_ptr=0, next_ptr_val=0} to the new address. After the write, mode NEW_HEAD goes to HEAD_UPD_S; mode APPEND goes to UPDATE_TAIL_S.
- UPDATE_TAIL_S: wr_en_o = wr_avail_i, rewriting the tail entry with its stored key/value, next_ptr=new address, next_ptr_val=1. Then rescode INSERT_SUCCESS, go to RESULT_S. The new entry is always written before it is linked, so a concurrent search never follows a dangling pointer.
- HEAD_UPD_S: head_table_wr_en_o for exactly one cycle (bucket, new address, val=1). Then rescode INSERT_SUCCESS, go to RESULT_S.
- KEY_MATCH_S: see Optional Feature.
- RESULT_S: result_valid_o=1 and result_o stable until result_ready_i; then IDLE_S. Latency is counted from acceptance to result_valid_o.
- chain_state: NO_CHAIN for a new head. IN_HEAD / IN_MIDDLE / IN_TAIL for the match position. IN_TAIL_NO_MATCH for an append or table full.
- Only one of rd_en_o, wr_en_o, head_table_wr_en_o, empty_addr_rd_ack_o is high in any cycle.

Optional Feature:
Macro DATA_TABLE_INSERT_OVERWRITE_EN.
- Defined: KEY_MATCH_S performs wr_en_o (gated by wr_avail_i) of the matched entry with the new value, preserving next_ptr and next_ptr_val. Rescode INSERT_SUCCESS_SAME_KEY.
- Undefined: KEY_MATCH_S performs no write and goes straight to RESULT_S with rescode INSERT_NOT_SUCCESS_SAME_KEY.

Test Plan:
- Empty bucket 3, head_ptr_val=0, empty_addr_i=0x10 → one ack; write @0x10 {key, value, next_ptr_val=0}; head_table write (3, 0x10, 1); result INSERT_SUCCESS / NO_CHAIN.
- Chain 0x10→0x11, key not present, empty_addr_i=0x20 → reads 0x10 and 0x11; write @0x20; then write @0x11 with next_ptr=0x20, val=1 (in that order); result INSERT_SUCCESS / IN_TAIL_NO_MATCH.
- Same chain, key matches at 0x11 → with macro defined: write @0x11 with new value, next_ptr_val=0 kept, INSERT_SUCCESS_SAME_KEY / IN_TAIL. With macro undefined: no write, INSERT_NOT_SUCCESS_SAME_KEY.
- Chain tail reached, empty_addr_val_i=0 → no ack, no writes, INSERT_NOT_SUCCESS_TABLE_IS_FULL.
- rd_avail_i / wr_avail_i low for 5 cycles, rd_data_val_i 3 cycles late, result_ready_i held low for 4 cycles → no duplicate reads or writes; result held stable; task_ready_o low until accepted.
- rst_i asserted in UPDATE_TAIL_S → next cycle IDLE_S, all strobes low, task_ready_o=1; a new task completes normally.

Source files
------------

// File: rtl/data_table_insert_if.sv
// Shared payload types and the task/RAM/head-table/result bundle of data_table_insert.
// The slave modport is the insert engine side; master is the environment side.
package data_table_insert_pkg;
    localparam int unsigned KEY_WIDTH        = 16;
    localparam int unsigned VALUE_WIDTH      = 16;
    localparam int unsigned BUCKET_WIDTH     = 8;
    localparam int unsigned TABLE_ADDR_WIDTH = 8;
    localparam int unsigned A_WIDTH          = TABLE_ADDR_WIDTH;

    typedef struct packed {
        logic [KEY_WIDTH-1:0]   key;
        logic [VALUE_WIDTH-1:0] value;
    } ht_command_t;

    typedef struct packed {
        ht_command_t             cmd;
        logic [BUCKET_WIDTH-1:0] bucket;
        logic [A_WIDTH-1:0]      head_ptr;
        logic                    head_ptr_val;
    } ht_pdata_t;

    typedef struct packed {
        logic [KEY_WIDTH-1:0]   key;
        logic [VALUE_WIDTH-1:0] value;
        logic [A_WIDTH-1:0]     next_ptr;
        logic                   next_ptr_val;
    } ram_data_t;

    typedef enum logic [1:0] {
        INSERT_SUCCESS,
        INSERT_SUCCESS_SAME_KEY,
        INSERT_NOT_SUCCESS_SAME_KEY,
        INSERT_NOT_SUCCESS_TABLE_IS_FULL
    } ht_rescode_t;

    typedef enum logic [2:0] {
        NO_CHAIN,
        IN_HEAD,
        IN_MIDDLE,
        IN_TAIL,
        IN_TAIL_NO_MATCH
    } ht_chain_state_t;

    typedef struct packed {
        ht_command_t             cmd;
        logic [BUCKET_WIDTH-1:0] bucket;
        logic [VALUE_WIDTH-1:0]  found_value;
        ht_rescode_t             rescode;
        ht_chain_state_t         chain_state;
    } ht_result_t;
endpackage

interface data_table_insert_if;
    import data_table_insert_pkg::*;

    ht_pdata_t               task_i;
    logic                    task_valid_i;
    logic                    task_ready_o;
    logic                    rd_avail_i;
    logic [A_WIDTH-1:0]      rd_addr_o;
    logic                    rd_en_o;
    ram_data_t               rd_data_i;
    logic                    rd_data_val_i;
    logic                    wr_avail_i;
    logic [A_WIDTH-1:0]      wr_addr_o;
    ram_data_t               wr_data_o;
    logic                    wr_en_o;
    logic [A_WIDTH-1:0]      empty_addr_i;
    logic                    empty_addr_val_i;
    logic                    empty_addr_rd_ack_o;
    logic [BUCKET_WIDTH-1:0] head_table_wr_addr_o;
    logic [A_WIDTH-1:0]      head_table_wr_data_ptr_o;
    logic                    head_table_wr_data_ptr_val_o;
    logic                    head_table_wr_en_o;
    ht_result_t              result_o;
    logic                    result_valid_o;
    logic                    result_ready_i;

    modport slave (
        input  task_i, task_valid_i, rd_avail_i, rd_data_i, rd_data_val_i, wr_avail_i,
               empty_addr_i, empty_addr_val_i, result_ready_i,
        output task_ready_o, rd_addr_o, rd_en_o, wr_addr_o, wr_data_o, wr_en_o,
               empty_addr_rd_ack_o, head_table_wr_addr_o, head_table_wr_data_ptr_o,
               head_table_wr_data_ptr_val_o, head_table_wr_en_o, result_o, result_valid_o
    );

    modport master (
        output task_i, task_valid_i, rd_avail_i, rd_data_i, rd_data_val_i, wr_avail_i,
               empty_addr_i, empty_addr_val_i, result_ready_i,
        input  task_ready_o, rd_addr_o, rd_en_o, wr_addr_o, wr_data_o, wr_en_o,
               empty_addr_rd_ack_o, head_table_wr_addr_o, head_table_wr_data_ptr_o,
               head_table_wr_data_ptr_val_o, head_table_wr_en_o, result_o, result_valid_o
    );
endinterface

// File: rtl/data_table_insert.sv
// Hash table insert engine: walks a bucket chain, then overwrites, appends or creates a head.
// Optional: DATA_TABLE_INSERT_OVERWRITE_EN lets a key match overwrite the stored value.
module data_table_insert
    import data_table_insert_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    data_table_insert_if.slave bus
);

    localparam logic [3:0] IDLE_S        = 4'd0;
    localparam logic [3:0] READ_HEAD_S   = 4'd1;
    localparam logic [3:0] GO_ON_CHAIN_S = 4'd2;
    localparam logic [3:0] KEY_MATCH_S   = 4'd3;
    localparam logic [3:0] ALLOC_S       = 4'd4;
    localparam logic [3:0] WRITE_NEW_S   = 4'd5;
    localparam logic [3:0] UPDATE_TAIL_S = 4'd6;
    localparam logic [3:0] HEAD_UPD_S    = 4'd7;
    localparam logic [3:0] RESULT_S      = 4'd8;

    logic [3:0]              state_q, state_d;
    ht_command_t             cmd_q, cmd_d;
    logic [BUCKET_WIDTH-1:0] bucket_q, bucket_d;
    logic [A_WIDTH-1:0]      rd_addr_q, rd_addr_d;
    logic                    rd_pending_q, rd_pending_d;
    logic                    append_q, append_d;
    logic [KEY_WIDTH-1:0]    tail_key_q, tail_key_d;
    logic [VALUE_WIDTH-1:0]  tail_value_q, tail_value_d;
    logic [A_WIDTH-1:0]      new_addr_q, new_addr_d;
    ht_chain_state_t         chain_state_q, chain_state_d;
    ht_rescode_t             rescode_q, rescode_d;
`ifdef DATA_TABLE_INSERT_OVERWRITE_EN
    logic [A_WIDTH-1:0]      match_next_ptr_q, match_next_ptr_d;
    logic                    match_next_val_q, match_next_val_d;
`endif

    logic                    rd_en_c;
    logic                    wr_en_c;
    logic [A_WIDTH-1:0]      wr_addr_c;
    ram_data_t               wr_data_c;
    logic                    ack_c;
    logic                    head_wr_c;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= IDLE_S;
            cmd_q         <= '0;
            bucket_q      <= '0;
            rd_addr_q     <= '0;
            rd_pending_q  <= 1'b0;
            append_q      <= 1'b0;
            tail_key_q    <= '0;
            tail_value_q  <= '0;
            new_addr_q    <= '0;
            chain_state_q <= NO_CHAIN;
            rescode_q     <= INSERT_SUCCESS;
`ifdef DATA_TABLE_INSERT_OVERWRITE_EN
            match_next_ptr_q <= '0;
            match_next_val_q <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            cmd_q         <= cmd_d;
            bucket_q      <= bucket_d;
            rd_addr_q     <= rd_addr_d;
            rd_pending_q  <= rd_pending_d;
            append_q      <= append_d;
            tail_key_q    <= tail_key_d;
            tail_value_q  <= tail_value_d;
            new_addr_q    <= new_addr_d;
            chain_state_q <= chain_state_d;
            rescode_q     <= rescode_d;
`ifdef DATA_TABLE_INSERT_OVERWRITE_EN
            match_next_ptr_q <= match_next_ptr_d;
            match_next_val_q <= match_next_val_d;
`endif
        end
    end

    always_comb begin
        state_d       = state_q;
        cmd_d         = cmd_q;
        bucket_d      = bucket_q;
        rd_addr_d     = rd_addr_q;
        rd_pending_d  = rd_pending_q;
        append_d      = append_q;
        tail_key_d    = tail_key_q;
        tail_value_d  = tail_value_q;
        new_addr_d    = new_addr_q;
        chain_state_d = chain_state_q;
        rescode_d     = rescode_q;
`ifdef DATA_TABLE_INSERT_OVERWRITE_EN
        match_next_ptr_d = match_next_ptr_q;
        match_next_val_d = match_next_val_q;
`endif
        rd_en_c   = 1'b0;
        wr_en_c   = 1'b0;
        wr_addr_c = '0;
        wr_data_c = '0;
        ack_c     = 1'b0;
        head_wr_c = 1'b0;

        case (state_q)
            IDLE_S: begin
                if (bus.task_valid_i) begin
                    cmd_d        = bus.task_i.cmd;
                    bucket_d     = bus.task_i.bucket;
                    rd_pending_d = 1'b0;
                    if (!bus.task_i.head_ptr_val) begin
                        append_d      = 1'b0;
                        chain_state_d = NO_CHAIN;
                        state_d       = ALLOC_S;
                    end else begin
                        rd_addr_d = bus.task_i.head_ptr;
                        state_d   = READ_HEAD_S;
                    end
                end
            end
            READ_HEAD_S, GO_ON_CHAIN_S: begin
                // One read per visit; the pending flag blocks reissue until data returns.
                rd_en_c = bus.rd_avail_i && !rd_pending_q;
                if (rd_en_c) rd_pending_d = 1'b1;
                if (rd_pending_q && bus.rd_data_val_i) begin
                    rd_pending_d = 1'b0;
                    tail_key_d   = bus.rd_data_i.key;
                    tail_value_d = bus.rd_data_i.value;
`ifdef DATA_TABLE_INSERT_OVERWRITE_EN
                    match_next_ptr_d = bus.rd_data_i.next_ptr;
                    match_next_val_d = bus.rd_data_i.next_ptr_val;
`endif
                    if (bus.rd_data_i.key == cmd_q.key) begin
                        chain_state_d = (state_q == READ_HEAD_S) ? IN_HEAD :
                                        (bus.rd_data_i.next_ptr_val ? IN_MIDDLE : IN_TAIL);
                        state_d = KEY_MATCH_S;
                    end else if (!bus.rd_data_i.next_ptr_val) begin
                        append_d      = 1'b1;
                        chain_state_d = IN_TAIL_NO_MATCH;
                        state_d       = ALLOC_S;
                    end else begin
                        rd_addr_d = bus.rd_data_i.next_ptr;
                        state_d   = GO_ON_CHAIN_S;
                    end
                end
            end
            KEY_MATCH_S: begin
`ifdef DATA_TABLE_INSERT_OVERWRITE_EN
                wr_en_c   = bus.wr_avail_i;
                wr_addr_c = rd_addr_q;
                wr_data_c = '{key: cmd_q.key, value: cmd_q.value,
                              next_ptr: match_next_ptr_q, next_ptr_val: match_next_val_q};
                if (bus.wr_avail_i) begin
                    rescode_d = INSERT_SUCCESS_SAME_KEY;
                    state_d   = RESULT_S;
                end
`else
                rescode_d = INSERT_NOT_SUCCESS_SAME_KEY;
                state_d   = RESULT_S;
`endif
            end
            ALLOC_S: begin
                if (bus.empty_addr_val_i) begin
                    ack_c      = 1'b1;
                    new_addr_d = bus.empty_addr_i;
                    state_d    = WRITE_NEW_S;
                end else begin
                    rescode_d = INSERT_NOT_SUCCESS_TABLE_IS_FULL;
                    state_d   = RESULT_S;
                end
            end
            WRITE_NEW_S: begin
                // New entry lands before anything links to it.
                wr_en_c   = bus.wr_avail_i;
                wr_addr_c = new_addr_q;
                wr_data_c = '{key: cmd_q.key, value: cmd_q.value, next_ptr: '0, next_ptr_val: 1'b0};
                if (bus.wr_avail_i) state_d = append_q ? UPDATE_TAIL_S : HEAD_UPD_S;
            end
            UPDATE_TAIL_S: begin
                wr_en_c   = bus.wr_avail_i;
                wr_addr_c = rd_addr_q;
                wr_data_c = '{key: tail_key_q, value: tail_value_q,
                              next_ptr: new_addr_q, next_ptr_val: 1'b1};
                if (bus.wr_avail_i) begin
                    rescode_d = INSERT_SUCCESS;
                    state_d   = RESULT_S;
                end
            end
            HEAD_UPD_S: begin
                head_wr_c = 1'b1;
                rescode_d = INSERT_SUCCESS;
                state_d   = RESULT_S;
            end
            RESULT_S: begin
                if (bus.result_ready_i) state_d = IDLE_S;
            end
            default: state_d = IDLE_S;
        endcase
    end

    // Strobes are suppressed while reset is asserted so an abandoned task leaves no trace.
    assign bus.task_ready_o                 = (state_q == IDLE_S) && !rst_i;
    assign bus.rd_addr_o                    = rd_addr_q;
    assign bus.rd_en_o                      = rd_en_c && !rst_i;
    assign bus.wr_addr_o                    = wr_addr_c;
    assign bus.wr_data_o                    = wr_data_c;
    assign bus.wr_en_o                      = wr_en_c && !rst_i;
    assign bus.empty_addr_rd_ack_o          = ack_c && !rst_i;
    assign bus.head_table_wr_addr_o         = bucket_q;
    assign bus.head_table_wr_data_ptr_o     = new_addr_q;
    assign bus.head_table_wr_data_ptr_val_o = 1'b1;
    assign bus.head_table_wr_en_o           = head_wr_c && !rst_i;
    assign bus.result_valid_o               = (state_q == RESULT_S) && !rst_i;
    assign bus.result_o = '{cmd: cmd_q, bucket: bucket_q, found_value: '0,
                            rescode: rescode_q, chain_state: chain_state_q};

endmodule

// File: tb/tb_data_table_insert.sv
// Directed bench for data_table_insert with a behavioural data table RAM and strobe logs.
module tb_data_table_insert;
    import data_table_insert_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    data_table_insert_if bus ();

    data_table_insert dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    ram_data_t               mem [256];
    int                      rd_lat = 1;
    logic [A_WIDTH-1:0]      rd_log [$];
    logic [A_WIDTH-1:0]      wr_addr_log [$];
    ram_data_t               wr_data_log [$];
    logic [BUCKET_WIDTH-1:0] hb_log [$];
    logic [A_WIDTH-1:0]      hp_log [$];
    logic                    hv_log [$];
    int                      ack_cnt   = 0;
    int                      multi_cnt = 0;

    // RAM model: strobes logged at negedge, read data returned rd_lat cycles after the read.
    initial begin : ram_model
        int s;
        int rd_cd;
        logic [A_WIDTH-1:0] rd_pend;
        rd_cd = 0;
        rd_pend = '0;
        bus.rd_data_i = '0;
        bus.rd_data_val_i = 1'b0;
        forever begin
            @(negedge clk);
            s = int'(bus.rd_en_o) + int'(bus.wr_en_o) + int'(bus.head_table_wr_en_o)
                + int'(bus.empty_addr_rd_ack_o);
            if (s > 1) multi_cnt++;
            if (bus.rd_en_o) begin
                rd_log.push_back(bus.rd_addr_o);
                rd_pend = bus.rd_addr_o;
                rd_cd = rd_lat;
            end
            if (bus.wr_en_o) begin
                wr_addr_log.push_back(bus.wr_addr_o);
                wr_data_log.push_back(bus.wr_data_o);
                mem[bus.wr_addr_o] = bus.wr_data_o;
            end
            if (bus.empty_addr_rd_ack_o) ack_cnt++;
            if (bus.head_table_wr_en_o) begin
                hb_log.push_back(bus.head_table_wr_addr_o);
                hp_log.push_back(bus.head_table_wr_data_ptr_o);
                hv_log.push_back(bus.head_table_wr_data_ptr_val_o);
            end
            @(posedge clk);
            #1;
            bus.rd_data_val_i = 1'b0;
            if (rd_cd > 0) begin
                rd_cd--;
                if (rd_cd == 0) begin
                    bus.rd_data_i = mem[rd_pend];
                    bus.rd_data_val_i = 1'b1;
                end
            end
        end
    end

    function automatic ram_data_t mk_ent(input logic [15:0] k, input logic [15:0] v,
                                         input logic [7:0] p, input logic pv);
        return '{key: k, value: v, next_ptr: p, next_ptr_val: pv};
    endfunction

    function automatic ht_pdata_t mk_task(input logic [15:0] k, input logic [15:0] v,
                                          input logic [7:0] b, input logic [7:0] hp, input logic hv);
        return '{cmd: '{key: k, value: v}, bucket: b, head_ptr: hp, head_ptr_val: hv};
    endfunction

    function automatic ht_result_t mk_res(input logic [15:0] k, input logic [15:0] v,
                                          input logic [7:0] b, input ht_rescode_t rc,
                                          input ht_chain_state_t cs);
        return '{cmd: '{key: k, value: v}, bucket: b, found_value: '0, rescode: rc, chain_state: cs};
    endfunction

    function automatic logic [A_WIDTH-1:0] rd_at(input int i);
        return (rd_log.size() > i) ? rd_log[i] : 'x;
    endfunction
    function automatic logic [A_WIDTH-1:0] wa_at(input int i);
        return (wr_addr_log.size() > i) ? wr_addr_log[i] : 'x;
    endfunction
    function automatic ram_data_t wd_at(input int i);
        return (wr_data_log.size() > i) ? wr_data_log[i] : 'x;
    endfunction
    function automatic logic [16:0] head_at(input int i);
        return (hb_log.size() > i) ? {hb_log[i], hp_log[i], hv_log[i]} : 'x;
    endfunction

    task automatic clear_logs();
        rd_log.delete(); wr_addr_log.delete(); wr_data_log.delete();
        hb_log.delete(); hp_log.delete(); hv_log.delete();
        ack_cnt = 0;
    endtask

    task automatic set_chain();
        mem[8'h10] = mk_ent(16'h1111, 16'h00A0, 8'h11, 1'b1);
        mem[8'h11] = mk_ent(16'h2222, 16'h00A1, 8'h00, 1'b0);
    endtask

    // Presents one task, waits for acceptance and result_valid_o; retires it if ready is high.
    task automatic do_insert(input ht_pdata_t t, output ht_result_t res, output bit ok);
        res = '0;
        ok = 1'b0;
        clear_logs();
        @(posedge clk); #1;
        bus.task_i = t;
        bus.task_valid_i = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.task_ready_o) begin ok = 1'b1; break; end
        end
        @(posedge clk); #1;
        bus.task_valid_i = 1'b0;
        if (ok) begin
            ok = 1'b0;
            for (int i = 0; i < 300; i++) begin
                @(negedge clk);
                if (bus.result_valid_o) begin ok = 1'b1; res = bus.result_o; break; end
            end
        end
        if (bus.result_ready_i) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.task_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset task_ready: got %b expected 1", bus.task_ready_o); end
        n_checks++;
        if (bus.result_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset result_valid: got %b expected 0", bus.result_valid_o); end
        n_checks++;
        if ({bus.rd_en_o, bus.wr_en_o, bus.head_table_wr_en_o, bus.empty_addr_rd_ack_o} !== 4'b0000) begin
            n_fail++; $display("FAIL reset strobes: got %b expected 0000",
                {bus.rd_en_o, bus.wr_en_o, bus.head_table_wr_en_o, bus.empty_addr_rd_ack_o});
        end
        n_checks++;
        if (bus.rd_addr_o !== 8'h00) begin n_fail++; $display("FAIL reset rd_addr: got %h expected 00", bus.rd_addr_o); end
    endtask

    task automatic test_new_head();
        ht_result_t res;
        bit ok;
        bus.empty_addr_i = 8'h10;
        do_insert(mk_task(16'hABCD, 16'h1234, 8'd3, 8'h00, 1'b0), res, ok);
        n_checks++;
        if (ok !== 1'b1) begin n_fail++; $display("FAIL new_head timeout: got %b expected 1", ok); end
        n_checks++;
        if (res !== mk_res(16'hABCD, 16'h1234, 8'd3, INSERT_SUCCESS, NO_CHAIN)) begin
            n_fail++; $display("FAIL new_head result: got %h expected %h", res, mk_res(16'hABCD, 16'h1234, 8'd3, INSERT_SUCCESS, NO_CHAIN));
        end
        n_checks++;
        if (ack_cnt !== 1) begin n_fail++; $display("FAIL new_head ack count: got %0d expected 1", ack_cnt); end
        n_checks++;
        if (rd_log.size() !== 0) begin n_fail++; $display("FAIL new_head reads: got %0d expected 0", rd_log.size()); end
        n_checks++;
        if (wr_addr_log.size() !== 1 || wa_at(0) !== 8'h10) begin
            n_fail++; $display("FAIL new_head write addr: got %0d writes first %h expected 1 write at 10", wr_addr_log.size(), wa_at(0));
        end
        n_checks++;
        if (wd_at(0) !== mk_ent(16'hABCD, 16'h1234, 8'h00, 1'b0)) begin
            n_fail++; $display("FAIL new_head write data: got %h expected %h", wd_at(0), mk_ent(16'hABCD, 16'h1234, 8'h00, 1'b0));
        end
        n_checks++;
        if (hb_log.size() !== 1 || head_at(0) !== {8'd3, 8'h10, 1'b1}) begin
            n_fail++; $display("FAIL new_head head write: got %0d writes first %h expected 1 write %h", hb_log.size(), head_at(0), {8'd3, 8'h10, 1'b1});
        end
    endtask

    task automatic test_append();
        ht_result_t res;
        bit ok;
        set_chain();
        bus.empty_addr_i = 8'h20;
        do_insert(mk_task(16'h3333, 16'hBEEF, 8'd5, 8'h10, 1'b1), res, ok);
        n_checks++;
        if (ok !== 1'b1) begin n_fail++; $display("FAIL append timeout: got %b expected 1", ok); end
        n_checks++;
        if (res !== mk_res(16'h3333, 16'hBEEF, 8'd5, INSERT_SUCCESS, IN_TAIL_NO_MATCH)) begin
            n_fail++; $display("FAIL append result: got %h expected %h", res, mk_res(16'h3333, 16'hBEEF, 8'd5, INSERT_SUCCESS, IN_TAIL_NO_MATCH));
        end
        n_checks++;
        if (rd_log.size() !== 2 || rd_at(0) !== 8'h10 || rd_at(1) !== 8'h11) begin
            n_fail++; $display("FAIL append reads: got %0d reads %h %h expected 2 reads 10 11", rd_log.size(), rd_at(0), rd_at(1));
        end
        n_checks++;
        if (wr_addr_log.size() !== 2 || wa_at(0) !== 8'h20 || wa_at(1) !== 8'h11) begin
            n_fail++; $display("FAIL append write order: got %0d writes %h %h expected 20 then 11", wr_addr_log.size(), wa_at(0), wa_at(1));
        end
        n_checks++;
        if (wd_at(0) !== mk_ent(16'h3333, 16'hBEEF, 8'h00, 1'b0)) begin
            n_fail++; $display("FAIL append new entry: got %h expected %h", wd_at(0), mk_ent(16'h3333, 16'hBEEF, 8'h00, 1'b0));
        end
        n_checks++;
        if (wd_at(1) !== mk_ent(16'h2222, 16'h00A1, 8'h20, 1'b1)) begin
            n_fail++; $display("FAIL append tail link: got %h expected %h", wd_at(1), mk_ent(16'h2222, 16'h00A1, 8'h20, 1'b1));
        end
        n_checks++;
        if (ack_cnt !== 1 || hb_log.size() !== 0) begin
            n_fail++; $display("FAIL append ack/head: got ack %0d head %0d expected 1 and 0", ack_cnt, hb_log.size());
        end
    endtask

    task automatic test_key_match();
        ht_result_t res;
        bit ok;
        set_chain();
        do_insert(mk_task(16'h2222, 16'h5555, 8'd5, 8'h10, 1'b1), res, ok);
        n_checks++;
        if (ok !== 1'b1) begin n_fail++; $display("FAIL match_tail timeout: got %b expected 1", ok); end
        n_checks++;
        if (rd_log.size() !== 2 || ack_cnt !== 0) begin
            n_fail++; $display("FAIL match_tail reads/ack: got %0d reads ack %0d expected 2 and 0", rd_log.size(), ack_cnt);
        end
`ifdef DATA_TABLE_INSERT_OVERWRITE_EN
        n_checks++;
        if (res !== mk_res(16'h2222, 16'h5555, 8'd5, INSERT_SUCCESS_SAME_KEY, IN_TAIL)) begin
            n_fail++; $display("FAIL match_tail result: got %h expected %h", res, mk_res(16'h2222, 16'h5555, 8'd5, INSERT_SUCCESS_SAME_KEY, IN_TAIL));
        end
        n_checks++;
        if (wr_addr_log.size() !== 1 || wa_at(0) !== 8'h11 || wd_at(0) !== mk_ent(16'h2222, 16'h5555, 8'h00, 1'b0)) begin
            n_fail++; $display("FAIL match_tail overwrite: got %0d writes %h %h expected @11 %h", wr_addr_log.size(), wa_at(0), wd_at(0), mk_ent(16'h2222, 16'h5555, 8'h00, 1'b0));
        end
`else
        n_checks++;
        if (res !== mk_res(16'h2222, 16'h5555, 8'd5, INSERT_NOT_SUCCESS_SAME_KEY, IN_TAIL)) begin
            n_fail++; $display("FAIL match_tail result: got %h expected %h", res, mk_res(16'h2222, 16'h5555, 8'd5, INSERT_NOT_SUCCESS_SAME_KEY, IN_TAIL));
        end
        n_checks++;
        if (wr_addr_log.size() !== 0) begin n_fail++; $display("FAIL match_tail writes: got %0d expected 0", wr_addr_log.size()); end
`endif
        // Head match: chain position and preserved link.
        set_chain();
        do_insert(mk_task(16'h1111, 16'h7777, 8'd5, 8'h10, 1'b1), res, ok);
        n_checks++;
        if (res.chain_state !== IN_HEAD || rd_log.size() !== 1) begin
            n_fail++; $display("FAIL match_head: got state %0d reads %0d expected %0d and 1", res.chain_state, rd_log.size(), IN_HEAD);
        end
`ifdef DATA_TABLE_INSERT_OVERWRITE_EN
        n_checks++;
        if (wd_at(0) !== mk_ent(16'h1111, 16'h7777, 8'h11, 1'b1)) begin
            n_fail++; $display("FAIL match_head overwrite: got %h expected %h", wd_at(0), mk_ent(16'h1111, 16'h7777, 8'h11, 1'b1));
        end
`else
        n_checks++;
        if (wr_addr_log.size() !== 0) begin n_fail++; $display("FAIL match_head writes: got %0d expected 0", wr_addr_log.size()); end
`endif
    endtask

    task automatic test_table_full();
        ht_result_t res;
        bit ok;
        set_chain();
        bus.empty_addr_i = 8'h40;
        bus.empty_addr_val_i = 1'b0;
        do_insert(mk_task(16'h4444, 16'h0044, 8'd6, 8'h10, 1'b1), res, ok);
        bus.empty_addr_val_i = 1'b1;
        n_checks++;
        if (ok !== 1'b1) begin n_fail++; $display("FAIL full timeout: got %b expected 1", ok); end
        n_checks++;
        if (res !== mk_res(16'h4444, 16'h0044, 8'd6, INSERT_NOT_SUCCESS_TABLE_IS_FULL, IN_TAIL_NO_MATCH)) begin
            n_fail++; $display("FAIL full result: got %h expected %h", res, mk_res(16'h4444, 16'h0044, 8'd6, INSERT_NOT_SUCCESS_TABLE_IS_FULL, IN_TAIL_NO_MATCH));
        end
        n_checks++;
        if (ack_cnt !== 0 || wr_addr_log.size() !== 0 || hb_log.size() !== 0) begin
            n_fail++; $display("FAIL full side effects: got ack %0d writes %0d head %0d expected all 0", ack_cnt, wr_addr_log.size(), hb_log.size());
        end
    endtask

    task automatic test_back_to_back_stall();
        ht_result_t res;
        ht_result_t exp;
        bit ok;
        set_chain();
        exp = mk_res(16'h5A5A, 16'h0C0C, 8'd5, INSERT_SUCCESS, IN_TAIL_NO_MATCH);
        bus.empty_addr_i = 8'h20;
        bus.rd_avail_i = 1'b0;
        bus.wr_avail_i = 1'b0;
        bus.result_ready_i = 1'b0;
        rd_lat = 3;
        fork
            do_insert(mk_task(16'h5A5A, 16'h0C0C, 8'd5, 8'h10, 1'b1), res, ok);
            begin
                repeat (6) @(posedge clk);
                #1 bus.rd_avail_i = 1'b1;
                repeat (20) @(posedge clk);
                #1 bus.wr_avail_i = 1'b1;
            end
        join
        n_checks++;
        if (ok !== 1'b1) begin n_fail++; $display("FAIL stall timeout: got %b expected 1", ok); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if (bus.result_valid_o !== 1'b1 || bus.result_o !== exp || bus.task_ready_o !== 1'b0) begin
                n_fail++; $display("FAIL stall hold cycle %0d: got valid %b ready %b result %h expected 1 0 %h",
                    i, bus.result_valid_o, bus.task_ready_o, bus.result_o, exp);
            end
        end
        @(posedge clk); #1 bus.result_ready_i = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++;
        if (bus.result_valid_o !== 1'b0 || bus.task_ready_o !== 1'b1) begin
            n_fail++; $display("FAIL stall retire: got valid %b ready %b expected 0 1", bus.result_valid_o, bus.task_ready_o);
        end
        n_checks++;
        if (rd_log.size() !== 2 || rd_at(0) !== 8'h10 || rd_at(1) !== 8'h11) begin
            n_fail++; $display("FAIL stall reads: got %0d reads %h %h expected 2 reads 10 11", rd_log.size(), rd_at(0), rd_at(1));
        end
        n_checks++;
        if (wr_addr_log.size() !== 2 || wa_at(0) !== 8'h20 || wa_at(1) !== 8'h11 || ack_cnt !== 1) begin
            n_fail++; $display("FAIL stall writes: got %0d writes %h %h ack %0d expected 20 11 ack 1", wr_addr_log.size(), wa_at(0), wa_at(1), ack_cnt);
        end
        rd_lat = 1;
    endtask

    task automatic test_reset_mid_task();
        ht_result_t res;
        bit ok;
        bit seen;
        set_chain();
        bus.empty_addr_i = 8'h30;
        clear_logs();
        @(posedge clk); #1;
        bus.task_i = mk_task(16'h6666, 16'h0066, 8'd9, 8'h10, 1'b1);
        bus.task_valid_i = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.task_ready_o) begin seen = 1'b1; break; end
        end
        @(posedge clk); #1 bus.task_valid_i = 1'b0;
        if (seen) begin
            seen = 1'b0;
            for (int i = 0; i < 100; i++) begin
                @(negedge clk);
                if (bus.wr_en_o) begin seen = 1'b1; break; end
            end
        end
        n_checks++;
        if (seen !== 1'b1) begin n_fail++; $display("FAIL rst_mid new-entry write timeout: got %b expected 1", seen); end
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.wr_en_o !== 1'b0) begin n_fail++; $display("FAIL rst_mid write during reset: got %b expected 0", bus.wr_en_o); end
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({bus.task_ready_o, bus.result_valid_o, bus.rd_en_o, bus.wr_en_o, bus.empty_addr_rd_ack_o, bus.head_table_wr_en_o} !== 6'b100000) begin
            n_fail++; $display("FAIL rst_mid after reset: got %b expected 100000",
                {bus.task_ready_o, bus.result_valid_o, bus.rd_en_o, bus.wr_en_o, bus.empty_addr_rd_ack_o, bus.head_table_wr_en_o});
        end
        repeat (4) @(negedge clk);
        n_checks++;
        if (wr_addr_log.size() !== 1 || wa_at(0) !== 8'h30) begin
            n_fail++; $display("FAIL rst_mid abandoned writes: got %0d writes first %h expected 1 at 30", wr_addr_log.size(), wa_at(0));
        end
        bus.empty_addr_i = 8'h31;
        do_insert(mk_task(16'h7777, 16'h0077, 8'd7, 8'h00, 1'b0), res, ok);
        n_checks++;
        if (ok !== 1'b1 || res !== mk_res(16'h7777, 16'h0077, 8'd7, INSERT_SUCCESS, NO_CHAIN)) begin
            n_fail++; $display("FAIL rst_mid next task: got ok %b result %h expected 1 %h", ok, res, mk_res(16'h7777, 16'h0077, 8'd7, INSERT_SUCCESS, NO_CHAIN));
        end
        n_checks++;
        if (wa_at(0) !== 8'h31 || head_at(0) !== {8'd7, 8'h31, 1'b1}) begin
            n_fail++; $display("FAIL rst_mid next writes: got %h head %h expected 31 head %h", wa_at(0), head_at(0), {8'd7, 8'h31, 1'b1});
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.task_i = '0;
        bus.task_valid_i = 1'b0;
        bus.rd_avail_i = 1'b1;
        bus.wr_avail_i = 1'b1;
        bus.empty_addr_i = '0;
        bus.empty_addr_val_i = 1'b1;
        bus.result_ready_i = 1'b1;
        test_reset();
        test_new_head();
        test_append();
        test_key_match();
        test_table_full();
        test_back_to_back_stall();
        test_reset_mid_task();
        n_checks++;
        if (multi_cnt !== 0) begin n_fail++; $display("FAIL strobe exclusivity: got %0d overlapping cycles expected 0", multi_cnt); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
